// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU command sequencer.
// Contents:
//   ALU_W      - datapath width of the ALU operands and results
//   state_e    - sequencer states (IDLE/ISSUE/WAIT/RESP)
//   CLS_*      - 2-bit unit class codes taken from ALU_FUN[3:2]
//   fun_class  - extracts the unit class from a 4-bit function code
package alu_ctrl_pkg;

    localparam int unsigned ALU_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_CMP   = 2'b10;
    localparam logic [1:0] CLS_SHIFT = 2'b11;

    function automatic logic [1:0] fun_class(input logic [3:0] fun);
        return fun[3:2];
    endfunction

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// Command/response handshake bundle between the system control FSM and
// the ALU command sequencer.
//   master : requester side (drives cmd_* and res_ready)
//   slave  : sequencer side (drives cmd_ready and res_*)
interface alu_cmd_ctrl_if;
    import alu_ctrl_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_fun;
    logic [ALU_W-1:0] cmd_a;
    logic [ALU_W-1:0] cmd_b;
    logic             cmd_acc;

    logic             res_valid;
    logic             res_ready;
    logic [ALU_W-1:0] res_data;
    logic             res_carry;
    logic             res_err;

    modport master (
        output cmd_valid, cmd_fun, cmd_a, cmd_b, cmd_acc, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_err
    );

    modport slave (
        input  cmd_valid, cmd_fun, cmd_a, cmd_b, cmd_acc, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_err
    );

endinterface

// File: rtl/alu_result_sel.sv
// Combinational selection of the ALU unit output, valid flag and carry for
// the class given by ALU_FUN[3:2].
//   cls            - unit class (arith/logic/cmp/shift)
//   *_out, *_flag  - per-unit output and valid flag from the ALU
//   carry_out      - ALU carry, meaningful only for the arithmetic unit
//   data/flag/carry- selected values; carry is forced to 0 outside arith
module alu_result_sel
    import alu_ctrl_pkg::*;
(
    input  logic [1:0]       cls,
    input  logic [ALU_W-1:0] arith_out,
    input  logic [ALU_W-1:0] logic_out,
    input  logic [ALU_W-1:0] cmp_out,
    input  logic [ALU_W-1:0] shift_out,
    input  logic             carry_out,
    input  logic             arith_flag,
    input  logic             logic_flag,
    input  logic             cmp_flag,
    input  logic             shift_flag,
    output logic [ALU_W-1:0] data,
    output logic             flag,
    output logic             carry
);

    // Unit multiplexer keyed on the function class
    always_comb begin
        data  = {ALU_W{1'b0}};
        flag  = 1'b0;
        carry = 1'b0;
        case (cls)
            CLS_ARITH: begin
                data  = arith_out;
                flag  = arith_flag;
                carry = carry_out;
            end
            CLS_LOGIC: begin
                data = logic_out;
                flag = logic_flag;
            end
            CLS_CMP: begin
                data = cmp_out;
                flag = cmp_flag;
            end
            CLS_SHIFT: begin
                data = shift_out;
                flag = shift_flag;
            end
            default: begin
                data  = {ALU_W{1'b0}};
                flag  = 1'b0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// ALU command sequencer. Accepts one command at a time, presents it to the
// clocked ALU, enables the ALU clock for exactly ALU_LAT edges, samples the
// selected unit one cycle later and returns the result over a handshake.
// Ports:
//   CLK, RST (async active-low)
//   bus        - command/response handshake (slave modport)
//   ALU_FUN/A/B, ALU_CLK_EN - drive to the ALU (held between commands)
//   *_OUT, Carry_OUT, *_Flag - ALU unit results
// Parameter ALU_LAT (1..7): enabled ALU edges until outputs are valid.
// Optional feature macro ALU_CTRL_ACC_EN: a result accumulator usable as
// operand A via cmd_acc; without it cmd_acc is ignored.
module alu_cmd_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    alu_cmd_ctrl_if.slave    bus,
    output logic [3:0]       ALU_FUN,
    output logic [ALU_W-1:0] A,
    output logic [ALU_W-1:0] B,
    output logic             ALU_CLK_EN,
    input  logic [ALU_W-1:0] Arith_OUT,
    input  logic [ALU_W-1:0] Logic_OUT,
    input  logic [ALU_W-1:0] CMP_OUT,
    input  logic [ALU_W-1:0] Shift_OUT,
    input  logic             Carry_OUT,
    input  logic             Arith_Flag,
    input  logic             Logic_Flag,
    input  logic             CMP_Flag,
    input  logic             Shift_Flag
);

    // Counter is loaded with LAT-1 so ISSUE lasts exactly ALU_LAT cycles.
    localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 32'd1);

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [3:0]       fun_q, fun_d;
    logic [ALU_W-1:0] a_q, a_d, b_q, b_d;
    logic [ALU_W-1:0] data_q, data_d;
    logic             carry_q, carry_d, err_q, err_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             clk_en_q, clk_en_d;

    logic [ALU_W-1:0] sel_data_s;
    logic             sel_flag_s, sel_carry_s;
    logic [ALU_W-1:0] opa_s;

`ifdef ALU_CTRL_ACC_EN
    logic [ALU_W-1:0] acc_q, acc_d;

    // Operand A source: accumulator or command operand
    always_comb begin
        if (bus.cmd_acc) begin
            opa_s = acc_q;
        end else begin
            opa_s = bus.cmd_a;
        end
    end
`else
    logic unused_acc_s;
    assign unused_acc_s = bus.cmd_acc;
    assign opa_s        = bus.cmd_a;
`endif

    alu_result_sel u_sel (
        .cls        (fun_class(fun_q)),
        .arith_out  (Arith_OUT),
        .logic_out  (Logic_OUT),
        .cmp_out    (CMP_OUT),
        .shift_out  (Shift_OUT),
        .carry_out  (Carry_OUT),
        .arith_flag (Arith_Flag),
        .logic_flag (Logic_Flag),
        .cmp_flag   (CMP_Flag),
        .shift_flag (Shift_Flag),
        .data       (sel_data_s),
        .flag       (sel_flag_s),
        .carry      (sel_carry_s)
    );

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fun_d   = fun_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        carry_d = carry_q;
        err_d   = err_q;
`ifdef ALU_CTRL_ACC_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // cmd_ready is registered; it is 0 in the first cycle after reset
                if (bus.cmd_valid && cmd_ready_q) begin
                    fun_d   = bus.cmd_fun;
                    a_d     = opa_s;
                    b_d     = bus.cmd_b;
                    cnt_d   = LAT_M1;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_WAIT: begin
                // Data and carry are kept even when the flag reports an error
                data_d  = sel_data_s;
                carry_d = sel_carry_s;
                err_d   = ~sel_flag_s;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.res_ready) begin
`ifdef ALU_CTRL_ACC_EN
                    if (!err_q) begin
                        acc_d = data_q;
                    end else begin
                        acc_d = acc_q;
                    end
`endif
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are registered from the state being entered
        cmd_ready_d = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_RESP);
        clk_en_d    = (state_d == ST_ISSUE);
    end

    // Sequencer state and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            fun_q       <= 4'd0;
            a_q         <= {ALU_W{1'b0}};
            b_q         <= {ALU_W{1'b0}};
            data_q      <= {ALU_W{1'b0}};
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            clk_en_q    <= 1'b0;
`ifdef ALU_CTRL_ACC_EN
            acc_q       <= {ALU_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fun_q       <= fun_d;
            a_q         <= a_d;
            b_q         <= b_d;
            data_q      <= data_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            clk_en_q    <= clk_en_d;
`ifdef ALU_CTRL_ACC_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign ALU_FUN       = fun_q;
    assign A             = a_q;
    assign B             = b_q;
    assign ALU_CLK_EN    = clk_en_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = data_q;
    assign bus.res_carry = carry_q;
    assign bus.res_err   = err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl. Two instances (ALU_LAT=1 and 3)
// each drive a behavioural ALU stub whose unit flag only rises after
// ALU_LAT consecutive enabled clock edges. Expected results come from a
// command-level reference model. Accumulator steps run when
// ALU_CTRL_ACC_EN is defined.
module tb_alu_cmd_ctrl;
    import alu_ctrl_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    alu_cmd_ctrl_if if1 ();
    alu_cmd_ctrl_if if3 ();

    // Bench drive variables; sel picks which instance receives cmd_valid
    logic        sel = 1'b0;
    logic        d_valid = 1'b0;
    logic [3:0]  d_fun = 4'd0;
    logic [15:0] d_a = 16'd0, d_b = 16'd0;
    logic        d_acc = 1'b0, d_rr = 1'b0;
    logic [3:0]  fe_mask = 4'd0;

    assign if1.cmd_valid = d_valid & ~sel;
    assign if3.cmd_valid = d_valid & sel;
    assign if1.cmd_fun = d_fun;  assign if3.cmd_fun = d_fun;
    assign if1.cmd_a   = d_a;    assign if3.cmd_a   = d_a;
    assign if1.cmd_b   = d_b;    assign if3.cmd_b   = d_b;
    assign if1.cmd_acc = d_acc;  assign if3.cmd_acc = d_acc;
    assign if1.res_ready = d_rr; assign if3.res_ready = d_rr;

    // ALU stub behaviour per unit class
    function automatic logic [15:0] unit_val(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b);
        case (c)
            2'd0:    return a + b;
            2'd1:    return a ^ b;
            2'd2:    return (a == b) ? 16'h0001 : ((a > b) ? 16'h0002 : 16'h0004);
            default: return {a[14:0], 1'b0};
        endcase
    endfunction

    function automatic logic carry_val(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16];
    endfunction

    logic [3:0]  fun1, fun3;
    logic [15:0] a1, b1, a3, b3;
    logic        en1, en3;
    int          cnt1 = 0, cnt3 = 0;

    // Stub flags need ALU_LAT consecutive enabled edges
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin cnt1 <= 0; cnt3 <= 0; end
        else begin
            cnt1 <= en1 ? ((cnt1 < 7) ? cnt1 + 1 : cnt1) : 0;
            cnt3 <= en3 ? ((cnt3 < 7) ? cnt3 + 1 : cnt3) : 0;
        end
    end

    alu_cmd_ctrl #(.ALU_LAT(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .bus(if1.slave),
        .ALU_FUN(fun1), .A(a1), .B(b1), .ALU_CLK_EN(en1),
        .Arith_OUT(unit_val(2'd0, a1, b1)), .Logic_OUT(unit_val(2'd1, a1, b1)),
        .CMP_OUT(unit_val(2'd2, a1, b1)), .Shift_OUT(unit_val(2'd3, a1, b1)),
        .Carry_OUT(carry_val(a1, b1)),
        .Arith_Flag(fun1[3:2] == 2'd0 && cnt1 >= 1 && !fe_mask[0]),
        .Logic_Flag(fun1[3:2] == 2'd1 && cnt1 >= 1 && !fe_mask[1]),
        .CMP_Flag  (fun1[3:2] == 2'd2 && cnt1 >= 1 && !fe_mask[2]),
        .Shift_Flag(fun1[3:2] == 2'd3 && cnt1 >= 1 && !fe_mask[3])
    );

    alu_cmd_ctrl #(.ALU_LAT(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .bus(if3.slave),
        .ALU_FUN(fun3), .A(a3), .B(b3), .ALU_CLK_EN(en3),
        .Arith_OUT(unit_val(2'd0, a3, b3)), .Logic_OUT(unit_val(2'd1, a3, b3)),
        .CMP_OUT(unit_val(2'd2, a3, b3)), .Shift_OUT(unit_val(2'd3, a3, b3)),
        .Carry_OUT(carry_val(a3, b3)),
        .Arith_Flag(fun3[3:2] == 2'd0 && cnt3 >= 3 && !fe_mask[0]),
        .Logic_Flag(fun3[3:2] == 2'd1 && cnt3 >= 3 && !fe_mask[1]),
        .CMP_Flag  (fun3[3:2] == 2'd2 && cnt3 >= 3 && !fe_mask[2]),
        .Shift_Flag(fun3[3:2] == 2'd3 && cnt3 >= 3 && !fe_mask[3])
    );

    // Observation muxed onto the selected instance
    logic        m_rv, m_rc, m_re, m_cr, m_en;
    logic [15:0] m_rd, m_a, m_b;
    logic [3:0]  m_fun;
    assign m_rv  = sel ? if3.res_valid : if1.res_valid;
    assign m_rd  = sel ? if3.res_data  : if1.res_data;
    assign m_rc  = sel ? if3.res_carry : if1.res_carry;
    assign m_re  = sel ? if3.res_err   : if1.res_err;
    assign m_cr  = sel ? if3.cmd_ready : if1.cmd_ready;
    assign m_en  = sel ? en3 : en1;
    assign m_a   = sel ? a3 : a1;
    assign m_b   = sel ? b3 : b1;
    assign m_fun = sel ? fun3 : fun1;

    logic [15:0] acc_m [2];

    // Reference: {err, carry, data} for a command presented with operands a/b
    function automatic logic [17:0] model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        logic [1:0] c;
        c = f[3:2];
        return {fe_mask[c], (c == 2'd0) ? carry_val(a, b) : 1'b0, unit_val(c, a, b)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full command; hold = cycles res_ready stays low once in RESP
    task automatic run_cmd(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                           input logic acc, input int hold);
        int n, m, en_cnt, lat, idx;
        logic [15:0] ea;
        logic [17:0] ev;
        idx = sel ? 1 : 0;
        lat = sel ? 3 : 1;
        ea  = a;
`ifdef ALU_CTRL_ACC_EN
        if (acc) ea = acc_m[idx];
`endif
        ev = model(f, ea, b);
        n = 0;
        while (m_cr !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
        chk("cmd_ready_idle", 32'(m_cr), 32'd1);
        d_fun = f; d_a = a; d_b = b; d_acc = acc; d_valid = 1'b1; d_rr = (hold == 0);
        @(posedge CLK);
        @(negedge CLK);
        d_valid = 1'b0;
        chk("alu_fun", 32'(m_fun), 32'(f));
        chk("alu_a", 32'(m_a), 32'(ea));
        chk("alu_b", 32'(m_b), 32'(b));
        chk("cmd_ready_busy", 32'(m_cr), 32'd0);
        m = 0; en_cnt = 0;
        while (m_rv !== 1'b1 && m < 20) begin
            if (m_en === 1'b1) en_cnt++;
            @(negedge CLK);
            m++;
        end
        chk("res_latency", 32'(m), 32'(lat + 1));
        chk("clk_en_cycles", 32'(en_cnt), 32'(lat));
        chk("res_data", 32'(m_rd), 32'(ev[15:0]));
        chk("res_carry", 32'(m_rc), 32'(ev[16]));
        chk("res_err", 32'(m_re), 32'(ev[17]));
        chk("cmd_ready_resp", 32'(m_cr), 32'd0);
        chk("clk_en_resp", 32'(m_en), 32'd0);
        if (hold > 0) begin
            // A competing command must not be taken while the response waits
            d_fun = ~f; d_a = a ^ 16'h5a5a; d_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge CLK);
                chk("hold_valid", 32'(m_rv), 32'd1);
                chk("hold_data", 32'(m_rd), 32'(ev[15:0]));
                chk("hold_cmd_ready", 32'(m_cr), 32'd0);
            end
            d_rr = 1'b1;
        end
        @(negedge CLK);
        chk("post_hs_valid", 32'(m_rv), 32'd0);
        chk("post_hs_cmd_ready", 32'(m_cr), 32'd1);
        chk("post_hs_a_kept", 32'(m_a), 32'(ea));
        d_valid = 1'b0; d_rr = 1'b0;
        if (!ev[17]) acc_m[idx] = ev[15:0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_m[0] = 16'd0; acc_m[1] = 16'd0;
        // Reset state
        #1;
        chk("rst_cmd_ready", 32'(m_cr), 32'd0);
        chk("rst_res_valid", 32'(m_rv), 32'd0);
        chk("rst_clk_en", 32'(m_en), 32'd0);
        chk("rst_alu_a", 32'(m_a), 32'd0);
        chk("rst_res_data", 32'(m_rd), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("cmd_ready_after_rst", 32'(m_cr), 32'd1);

        // ALU_LAT=1 directed steps
        sel = 1'b0;
        run_cmd(4'b0000, 16'h0005, 16'h0003, 1'b0, 0);
        run_cmd(4'b0000, 16'hFFFF, 16'h0001, 1'b0, 0);
        run_cmd(4'b1000, 16'hFFFF, 16'h0001, 1'b0, 0);
        run_cmd(4'b0100, 16'h1234, 16'h00FF, 1'b0, 5);
        fe_mask = 4'b1000;
        run_cmd(4'b1100, 16'h0101, 16'h0000, 1'b0, 0);
        fe_mask = 4'b0000;
        run_cmd(4'b0000, 16'h0010, 16'h0020, 1'b0, 0);

        // ALU_LAT=3 and asynchronous reset during ISSUE
        sel = 1'b1;
        run_cmd(4'b0001, 16'h7000, 16'h9000, 1'b0, 2);
        d_fun = 4'b0000; d_a = 16'h0042; d_b = 16'h0001; d_acc = 1'b0; d_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        d_valid = 1'b0;
        @(negedge CLK);
        chk("issue_clk_en", 32'(m_en), 32'd1);
        #2 RST = 1'b0;
        #1;
        chk("arst_clk_en", 32'(m_en), 32'd0);
        chk("arst_cmd_ready", 32'(m_cr), 32'd0);
        chk("arst_alu_a", 32'(m_a), 32'd0);
        chk("arst_alu_fun", 32'(m_fun), 32'd0);
        chk("arst_res_valid", 32'(m_rv), 32'd0);
        acc_m[0] = 16'd0; acc_m[1] = 16'd0;
        @(negedge CLK);
        RST = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge CLK);
                if (m_rv === 1'b1) seen++;
            end
            chk("no_resp_after_rst", 32'(seen), 32'd0);
        end
        chk("cmd_ready_after_arst", 32'(m_cr), 32'd1);

`ifdef ALU_CTRL_ACC_EN
        sel = 1'b0;
        run_cmd(4'b0000, 16'h0002, 16'h0003, 1'b0, 0);
        run_cmd(4'b0000, 16'hDEAD, 16'h0004, 1'b1, 0);
        fe_mask = 4'b0001;
        run_cmd(4'b0000, 16'hBEEF, 16'h0001, 1'b1, 0);
        fe_mask = 4'b0000;
        run_cmd(4'b0000, 16'h1111, 16'h0000, 1'b1, 0);
`endif

        // Randomized commands on both instances
        for (int k = 0; k < 30; k++) begin
            sel = 1'($urandom_range(0, 1));
            fe_mask = ($urandom_range(0, 5) == 0) ? 4'hF : 4'h0;
            run_cmd(4'($urandom), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end
        fe_mask = 4'h0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command sequencer for the 16-bit clocked ALU (ALU_TOP). It accepts one operation at a time over a valid/ready command port, drives ALU_FUN/A/B, and enables the ALU clock-gate only for the edges the ALU needs. It then selects the output and flag of the unit chosen by ALU_FUN[3:2] and returns the result over a valid/ready response port. It sits between the system control FSM and the ALU, and is the ALU's only driver.

## Interface
- ALU_LAT, 1, number of ALU clock edges between operand presentation and valid unit output/flag (1..7)
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_fun  in  4  ALU function code
- cmd_a, cmd_b  in  16 each  operands
- cmd_acc  in  1  use accumulator as operand A (see Configuration)
- ALU_FUN  out  4  to ALU
- A, B  out  16 each  to ALU
- ALU_CLK_EN  out  1  ALU clock-gate enable
- Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT  in  16 each  ALU unit outputs
- Carry_OUT  in  1  ALU carry
- Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  in  1 each  ALU unit valid flags
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts result
- res_data  out  16  selected unit output
- res_carry  out  1  Carry_OUT for arithmetic class, else 0
- res_err  out  1  selected flag was low at the sample point

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, register fun/a/b, go to ISSUE.
  - ISSUE: ALU_CLK_EN=1 for exactly ALU_LAT cycles, counted by a 3-bit down-counter, then go to WAIT.
  - WAIT: one cycle, ALU_CLK_EN=0. Sample the selected unit's output, flag and carry into the result registers, then go to RESP.
  - RESP: res_valid=1. On res_ready, go to IDLE.
- Class select on fun[3:2]: 00 arith, 01 logic, 10 cmp, 11 shift.
- res_err = NOT(selected flag) at the WAIT sample. On error, res_data and res_carry are still loaded with the sampled values.
- ALU_FUN/A/B come from the command registers and hold their last values in every state. There is no idle toggling.
- cmd_ready=0 in ISSUE, WAIT and RESP. Commands are never dropped or queued.
- Reset values: all outputs 0, including cmd_ready. State is IDLE, counter 0, result registers 0.
- RST asserted mid-operation: ALU_CLK_EN drops immediately (asynchronously). The in-flight command is discarded and no response is produced.

## Timing
- The accept edge is the edge where cmd_valid && cmd_ready.
- res_valid rises ALU_LAT+1 edges after the accept edge.
- The response handshake completes on the edge where res_valid && res_ready. cmd_ready is high in the following cycle.
- Minimum command period: ALU_LAT+3 cycles.
- ALU_CLK_EN is a registered output, high for exactly ALU_LAT consecutive cycles per command.
- res_data, res_carry and res_err are stable throughout RESP.
- A res_ready that is held high before res_valid rises is legal and completes in the first RESP cycle.

## Configuration
- ALU_CTRL_ACC_EN defined:
  - A 16-bit accumulator (reset 0) is loaded with res_data at every completed response handshake where res_err=0.
  - On an accepted command with cmd_acc=1, operand A is taken from the accumulator instead of cmd_a.
- ALU_CTRL_ACC_EN undefined: no accumulator register exists and cmd_acc is ignored. The port stays present.

## Structure
- Package alu_ctrl_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP)
  - the 2-bit class codes
  - width constant 16
- Sub-module alu_result_sel is combinational. It takes the class and the four output/flag pairs plus Carry_OUT, and returns data, flag and carry. It is instantiated once, feeding the WAIT sample.

## Test plan
- ALU_LAT=1, fun=0000 (add), a=0005, b=0003, res_ready=1 → res_valid two edges after accept, res_data=0008, res_carry=0, res_err=0, ALU_CLK_EN high exactly 1 cycle.
- Add a=FFFF, b=0001 → res_data=0000, res_carry=1. Then a cmp-class command (fun=10xx) → res_carry=0.
- res_ready held low 5 cycles in RESP → res_valid and res_data stable, cmd_ready=0 throughout. New cmd_valid is not accepted until the cycle after the handshake.
- ALU stub keeps Shift_Flag=0, fun=1100 → res_err=1. FSM returns to IDLE after the handshake and the next arith command completes with res_err=0.
- RST pulsed low during ISSUE with ALU_LAT=3 → ALU_CLK_EN and all outputs go 0 immediately, no res_valid follows, and cmd_ready=1 after release.
- ALU_CTRL_ACC_EN defined:
  - add 0002+0003 → 0005
  - then cmd_acc=1, add with b=0004 → 0009
  - then with an error response forced → accumulator remains 0009
